// File: rtl/dcache_wb_queue.sv
// Multi-entry write-back queue between the data cache and the AXI write channel.
// Drains entries in order as AXI bursts, merges same-line cached pushes, and serves refill lookups.
module dcache_wb_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic                      push_uncache,
    input  logic [ADDR_W-1:0]         push_addr,
    input  logic [3:0]                push_strb,
    input  logic [32*LINE_WORDS-1:0]  push_line,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      lookup_hit,
    output logic [32*LINE_WORDS-1:0]  lookup_line,
    output logic                      w_req,
    input  logic                      w_rdy,
    output logic [ADDR_W-1:0]         w_addr,
    output logic [7:0]                w_length,
    output logic [2:0]                w_size,
    output logic                      w_data_req,
    input  logic                      w_data_ready,
    output logic [31:0]               w_data_AXI,
    output logic [3:0]                w_strb,
    output logic                      w_last,
    output logic                      b_ready,
    input  logic                      b_valid,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;
    localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [7:0]     CACHED_LEN = 8'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [7:0]        beat_q, beat_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              valid_q   [DEPTH];
    logic              valid_d   [DEPTH];
    logic              uncache_q [DEPTH];
    logic              uncache_d [DEPTH];
    logic [ADDR_W-1:0] addr_q    [DEPTH];
    logic [ADDR_W-1:0] addr_d    [DEPTH];
    logic [3:0]        strb_q    [DEPTH];
    logic [3:0]        strb_d    [DEPTH];
    logic [LINE_W-1:0] line_q    [DEPTH];
    logic [LINE_W-1:0] line_d    [DEPTH];

    logic              merge_hit;
    logic [PTR_W-1:0]  merge_idx;
    logic              push_fire;
    logic              push_alloc;
    logic              pop;
    logic              busy;
    logic [PTR_W-1:0]  wr_idx;
    logic [LINE_W-1:0] head_line;

    // Scan oldest to youngest so the youngest eligible entry wins; the in-flight head is excluded.
    always_comb begin : merge_scan
        logic [PTR_W-1:0] idx;
        idx       = '0;
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && !uncache_q[idx] &&
                addr_q[idx][ADDR_W-1:OFF_W] == push_addr[ADDR_W-1:OFF_W] &&
                !(idx == head_q && state_q != S_IDLE)) begin
                merge_hit = 1'b1;
                merge_idx = idx;
            end
        end
    end

    always_comb begin : lookup_scan
        logic [PTR_W-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_line = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && !uncache_q[idx] &&
                addr_q[idx][ADDR_W-1:OFF_W] == lookup_addr[ADDR_W-1:OFF_W]) begin
                lookup_hit  = 1'b1;
                lookup_line = line_q[idx];
            end
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        head_line  = line_q[head_q];
        push_ready = (count_q != FULL_CNT);
        empty      = (count_q == '0);
        count      = count_q;
        w_req      = (state_q == S_AW);
        w_data_req = (state_q == S_W);
        b_ready    = (state_q == S_B);
        w_addr     = busy ? addr_q[head_q] : '0;
        w_length   = (busy && !uncache_q[head_q]) ? CACHED_LEN : '0;
        w_size     = busy ? 3'b010 : '0;
        w_strb     = w_data_req ? (uncache_q[head_q] ? strb_q[head_q] : 4'hf) : '0;
        w_data_AXI = w_data_req ? 32'(head_line >> {beat_q, 5'd0}) : '0;
        w_last     = w_data_req && (beat_q == w_length);
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        uncache_d = uncache_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        line_d    = line_q;

        push_fire  = push_valid && push_ready;
        push_alloc = push_fire && !(!push_uncache && merge_hit);
        pop        = (state_q == S_B) && b_valid;
        wr_idx     = push_alloc ? tail_q : merge_idx;

        if (push_fire) begin
            valid_d[wr_idx]   = 1'b1;
            uncache_d[wr_idx] = push_uncache;
            addr_d[wr_idx]    = push_addr;
            strb_d[wr_idx]    = push_strb;
            line_d[wr_idx]    = push_line;
        end
        if (push_alloc) tail_d = tail_q + 1'b1;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push_alloc && !pop) count_d = count_q + 1'b1;
        else if (!push_alloc && pop) count_d = count_q - 1'b1;

        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_AW;
            S_AW: if (w_rdy) begin
                state_d = S_W;
                beat_d  = '0;
            end
            S_W: if (w_data_ready) begin
                if (w_last) state_d = S_B;
                else beat_d = beat_q + 1'b1;
            end
            default: if (b_valid) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                uncache_q[i] <= 1'b0;
                addr_q[i]    <= '0;
                strb_q[i]    <= '0;
                line_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            uncache_q <= uncache_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            line_q    <= line_d;
        end
    end

endmodule

// File: tb/tb_dcache_wb_queue.sv
// Scoreboard bench for dcache_wb_queue: directed pushes queue expected AXI bursts,
// a negedge monitor pops and compares them at each AW/W handshake.
module tb_dcache_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned LBITS = 32 * LW;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid, push_ready, push_uncache;
    logic [AW-1:0]    push_addr;
    logic [3:0]       push_strb;
    logic [LBITS-1:0] push_line;
    logic [AW-1:0]    lookup_addr;
    logic             lookup_hit;
    logic [LBITS-1:0] lookup_line;
    logic             w_req, w_rdy;
    logic [AW-1:0]    w_addr;
    logic [7:0]       w_length;
    logic [2:0]       w_size;
    logic             w_data_req, w_data_ready;
    logic [31:0]      w_data_AXI;
    logic [3:0]       w_strb;
    logic             w_last, b_ready, b_valid, empty;
    logic [2:0]       count;

    dcache_wb_queue #(.DEPTH(DEPTH), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_uncache(push_uncache),
        .push_addr(push_addr), .push_strb(push_strb), .push_line(push_line),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_line(lookup_line),
        .w_req(w_req), .w_rdy(w_rdy), .w_addr(w_addr), .w_length(w_length), .w_size(w_size),
        .w_data_req(w_data_req), .w_data_ready(w_data_ready), .w_data_AXI(w_data_AXI),
        .w_strb(w_strb), .w_last(w_last), .b_ready(b_ready), .b_valid(b_valid),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
    aw_t aw_exp[$];
    w_t  w_exp[$];
    aw_t ae;
    w_t  we;

    int  checks = 0;
    int  failures = 0;
    int  w_beats = 0;
    bit  aw_en = 1'b1, wd_en = 1'b1, b_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [LBITS-1:0] make_line(input logic [31:0] base);
        logic [LBITS-1:0] l;
        for (int i = 0; i < LW; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic expect_burst(input logic [31:0] addr, input logic unc, input logic [3:0] strb,
                                input logic [LBITS-1:0] line);
        aw_t a;
        w_t  w;
        a.addr = addr;
        a.len  = unc ? 8'd0 : 8'd15;
        aw_exp.push_back(a);
        for (int i = 0; i < (unc ? 1 : LW); i++) begin
            w.data = line[i*32 +: 32];
            w.strb = unc ? strb : 4'hf;
            w.last = unc ? 1'b1 : (i == LW - 1);
            w_exp.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic unc, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [LBITS-1:0] line, output logic acc);
        push_valid   = 1'b1;
        push_uncache = unc;
        push_addr    = addr;
        push_strb    = strb;
        push_line    = line;
        acc          = push_ready;
        tick();
        push_valid   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (empty && !w_req && !w_data_req && !b_ready) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, done, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_push_ready"}, push_ready, 1);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_w_req"}, w_req, 0);
        chk({tag, "_w_data_req"}, w_data_req, 0);
        chk({tag, "_w_last"}, w_last, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_w_length"}, w_length, 0);
        chk({tag, "_w_data"}, w_data_AXI, 0);
        chk({tag, "_lookup_hit"}, lookup_hit, 0);
        chk_line({tag, "_lookup_line"}, lookup_line, '0);
    endtask

    // AXI slave responder: reacts to the request flags a little after each edge.
    initial begin
        w_rdy = 1'b0;
        w_data_ready = 1'b0;
        b_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            w_rdy        = aw_en && w_req;
            w_data_ready = wd_en && w_data_req;
            b_valid      = b_en && b_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst && w_req && w_rdy) begin
            if (aw_exp.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
                ae = aw_exp.pop_front();
                chk("aw_addr", w_addr, ae.addr);
                chk("aw_len", w_length, ae.len);
                chk("aw_size", w_size, 3'b010);
            end
        end
        if (!rst && w_data_req && w_data_ready) begin
            w_beats++;
            if (w_exp.size() == 0) chk("w_unexpected", 1, 0);
            else begin
                we = w_exp.pop_front();
                chk("w_data", w_data_AXI, we.data);
                chk("w_strb", w_strb, we.strb);
                chk("w_last", w_last, we.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             acc;
        logic [LBITS-1:0] l0, lu, lx, la, lb, la2, la3, lr;
        bit               ok, saw;
        int               base;

        rst = 1'b1;
        push_valid = 1'b0;
        push_uncache = 1'b0;
        push_addr = '0;
        push_strb = '0;
        push_line = '0;
        lookup_addr = '0;
        #3;
        chk_reset_outputs("rst");
        tick();
        rst = 1'b0;
        tick();

        // Cached 16-beat burst
        l0 = make_line(32'hA000_0000);
        expect_burst(32'h1000_0040, 1'b0, 4'h0, l0);
        push(1'b0, 32'h1000_0040, 4'h0, l0, acc);
        chk("s1_acc", acc, 1);
        chk("s1_count", count, 1);
        chk("s1_empty", empty, 0);
        chk("s1_no_early_wreq", w_req, 0);
        wait_idle("s1_drain");
        chk("s1_empty_after", empty, 1);
        chk("s1_count_after", count, 0);

        // Uncached single-word store
        lu = '0;
        lu[31:0] = 32'h0000_1234;
        expect_burst(32'h1FD0_0004, 1'b1, 4'b0011, lu);
        push(1'b1, 32'h1FD0_0004, 4'b0011, lu, acc);
        lookup_addr = 32'h1FD0_0000;
        #1;
        chk("s2_uncached_no_hit", lookup_hit, 0);
        wait_idle("s2_drain");

        // Fill to full, refused push, pop, simultaneous push+pop
        aw_en = 1'b0;
        b_en  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lx = make_line(32'hB000_0000 + 32'(k << 8));
            expect_burst(32'h2000 + 32'(k * 64), 1'b0, 4'h0, lx);
            push(1'b0, 32'h2000 + 32'(k * 64), 4'h0, lx, acc);
        end
        chk("s3_count_full", count, 4);
        chk("s3_ready_full", push_ready, 0);
        push(1'b0, 32'h3000, 4'h0, make_line(32'hEE00_0000), acc);
        chk("s3_refused", acc, 0);
        chk("s3_count_still", count, 4);
        aw_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = b_ready; end
        chk("s3_reach_b", ok, 1);
        chk("s3_count_in_b", count, 4);
        b_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = (count == 3); end
        b_en = 1'b0;
        chk("s3_popped", ok, 1);
        chk("s3_ready_after_pop", push_ready, 1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = b_ready; end
        chk("s3_reach_b2", ok, 1);
        b_en = 1'b1;
        lx = make_line(32'hF000_0000);
        expect_burst(32'h3000, 1'b0, 4'h0, lx);
        push(1'b0, 32'h3000, 4'h0, lx, acc);
        chk("s3_pushpop_acc", acc, 1);
        chk("s3_pushpop_count", count, 3);
        wait_idle("s3_drain");

        // Merge into a queued non-head entry; allocate when the head is in flight
        aw_en = 1'b0;
        lx  = make_line(32'hC000_0000);
        la  = make_line(32'hC100_0000);
        lb  = make_line(32'hC200_0000);
        la2 = make_line(32'hC300_0000);
        la3 = make_line(32'hC400_0000);
        push(1'b0, 32'h500, 4'h0, lx, acc);
        push(1'b0, 32'h100, 4'h0, la, acc);
        push(1'b0, 32'h140, 4'h0, lb, acc);
        chk("s4_count3", count, 3);
        push(1'b0, 32'h100, 4'h0, la2, acc);
        chk("s4_merge_acc", acc, 1);
        chk("s4_merge_count", count, 3);
        lookup_addr = 32'h108;
        #1;
        chk("s4_lookup_hit", lookup_hit, 1);
        chk_line("s4_lookup_line", lookup_line, la2);
        expect_burst(32'h500, 1'b0, 4'h0, lx);
        expect_burst(32'h100, 1'b0, 4'h0, la2);
        expect_burst(32'h140, 1'b0, 4'h0, lb);
        aw_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin tick(); ok = w_data_req && (w_addr == 32'h100); end
        chk("s4_head_a_in_w", ok, 1);
        expect_burst(32'h100, 1'b0, 4'h0, la3);
        push(1'b0, 32'h100, 4'h0, la3, acc);
        chk("s4_alloc_acc", acc, 1);
        chk("s4_alloc_count", count, 3);
        chk("s4_young_hit", lookup_hit, 1);
        chk_line("s4_young_line", lookup_line, la3);
        wait_idle("s4_drain");
        chk("s4_hit_after_pop", lookup_hit, 0);

        // Reset during W beat 5
        lr = make_line(32'hD000_0000);
        expect_burst(32'h7000, 1'b0, 4'h0, lr);
        base = w_beats;
        push(1'b0, 32'h7000, 4'h0, lr, acc);
        lookup_addr = 32'h7000;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = (w_beats - base == 5); end
        chk("s5_reach_beat5", ok, 1);
        chk("s5_hit_before_rst", lookup_hit, 1);
        rst = 1'b1;
        aw_exp.delete();
        w_exp.delete();
        #1;
        chk_reset_outputs("s5");
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (w_req) saw = 1'b1; end
        chk("s5_no_wreq", saw, 0);
        chk("s5_empty", empty, 1);

        chk("sb_aw_left", aw_exp.size(), 0);
        chk("sb_w_left", w_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
